// File: rtl/dm_store_buffer.sv
// dm_store_buffer
// Posted-write buffer between the MEM-stage store path and the data-memory
// write port. Stores are queued in program order, drained one per granted
// cycle, merged into the youngest entry when they hit the same word, and
// forwarded byte-wise over DM read data so loads observe program order.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   st_valid/st_ready store handshake (accepted when both high at the edge)
//   st_addr/be/data   word-aligned store (addr[1:0] ignored), lane-replicated
//   drain_en          DM write port granted this cycle
//   dm_wr/addr/be/din head entry presented to DM; written when dm_wr is high
//   ld_addr, dm_rdata load probe address and DM combinational read data
//   ld_rdata, ld_hit  merged load data and per-byte forward mask
//   count, empty      occupancy
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [31:0]   st_addr,
  input  logic [3:0]    st_be,
  input  logic [31:0]   st_data,
  input  logic          drain_en,
  output logic          dm_wr,
  output logic [31:0]   dm_addr,
  output logic [3:0]    dm_be,
  output logic [31:0]   dm_din,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   dm_rdata,
  output logic [31:0]   ld_rdata,
  output logic [3:0]    ld_hit,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  // Entry storage
  logic [29:0]   r_waddr [DEPTH];
  logic [3:0]    r_be    [DEPTH];
  logic [31:0]   r_data  [DEPTH];

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [AW-1:0] w_tail_m1;
  logic          w_full;
  logic          w_empty;
  logic          w_dm_wr;
  logic          w_co;
  logic          w_push;
  logic [31:0]   w_fwd_data;
  logic [3:0]    w_fwd_hit;

  // Overwrite the bytes of old_w selected by be with the bytes of new_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_w[8*b +: 8];
      end
    end
    return res;
  endfunction

  assign w_tail_m1 = r_tail - AW'(1'b1);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == {CW{1'b0}});
  assign w_dm_wr   = drain_en && !w_empty;

  // Merge into the youngest entry only if it is not the one leaving DM now;
  // otherwise the merged bytes would be lost with the drained entry.
  assign w_co = st_valid && !w_empty &&
                (st_addr[31:2] == r_waddr[w_tail_m1]) &&
                !((r_count == CW'(1)) && w_dm_wr);

  // A full buffer refuses new words even while draining (no same-cycle slot reuse).
  assign st_ready = !w_full || w_co;
  assign w_push   = st_valid && st_ready && !w_co;

  assign dm_wr   = w_dm_wr;
  assign dm_addr = {r_waddr[r_head], 2'b00};
  assign dm_be   = r_be[r_head];
  assign dm_din  = r_data[r_head];
  assign count   = r_count;
  assign empty   = w_empty;

  // Per-byte forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    w_fwd_data = dm_rdata;
    w_fwd_hit  = 4'b0000;
    for (int k = 0; k < DEPTH; k++) begin
      for (int b = 0; b < 4; b++) begin
        if ((CW'(k) < r_count) &&
            (r_waddr[r_head + AW'(k)] == ld_addr[31:2]) &&
            r_be[r_head + AW'(k)][b]) begin
          w_fwd_data[8*b +: 8] = r_data[r_head + AW'(k)][8*b +: 8];
          w_fwd_hit[b]         = 1'b1;
        end else begin
          w_fwd_data[8*b +: 8] = w_fwd_data[8*b +: 8];
          w_fwd_hit[b]         = w_fwd_hit[b];
        end
      end
    end
  end

  assign ld_rdata = w_fwd_data;
  assign ld_hit   = w_fwd_hit;

  // FIFO state: push/merge at the tail, drain at the head, occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= {AW{1'b0}};
      r_tail  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_waddr[i] <= 30'd0;
        r_be[i]    <= 4'b0000;
        r_data[i]  <= 32'd0;
      end
    end else begin
      if (w_push) begin
        r_waddr[r_tail] <= st_addr[31:2];
        r_be[r_tail]    <= st_be;
        r_data[r_tail]  <= st_data;
        r_tail          <= r_tail + AW'(1'b1);
      end else if (w_co) begin
        r_be[w_tail_m1]   <= r_be[w_tail_m1] | st_be;
        r_data[w_tail_m1] <= merge_bytes(r_data[w_tail_m1], st_data, st_be);
      end
      if (w_dm_wr) begin
        r_head <= r_head + AW'(1'b1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_dm_wr);
    end
  end

endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Posted-write buffer between the MEM-stage store path (after byte-enable/lane replication) and the data memory write port. Accepts word-aligned stores with byte enables, queues them in order, and drains one per cycle to DM when the port is granted. Merges consecutive same-word stores and forwards buffered bytes over DM read data, so loads see program-order memory contents. Merged load data then feeds the load extension stage.

## Interface
- DEPTH, 4: number of entries; power of two, at least 2.
- CW, 3: width of `count`; equals clog2(DEPTH)+1.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- st_valid  in  1  store request from MEM stage.
- st_ready  out  1  store accepted at this edge when high together with st_valid.
- st_addr  in  32  store byte address; only [31:2] is used.
- st_be  in  4  byte enables; bit i covers data[8i+7:8i].
- st_data  in  32  lane-replicated store data.
- drain_en  in  1  DM write port granted this cycle.
- dm_wr  out  1  DM write strobe.
- dm_addr  out  32  {head word address, 2'b00}.
- dm_be  out  4  head entry byte enables.
- dm_din  out  32  head entry data.
- ld_addr  in  32  load address probed this cycle.
- dm_rdata  in  32  DM combinational read data for ld_addr.
- ld_rdata  out  32  dm_rdata with buffered bytes overlaid.
- ld_hit  out  4  per-byte forward mask.
- count  out  CW  number of valid entries.
- empty  out  1  count == 0; used for fence/syscall drain.

## Operation
- Storage: circular FIFO of DEPTH entries {waddr[29:0], be[3:0], data[31:0]}, with head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- Drain:
  - dm_wr = drain_en && !empty.
  - dm_addr, dm_be, dm_din are taken from the head entry, which is registered state.
  - dm_be and dm_din are don't-care when dm_wr = 0.
  - When dm_wr is high, head advances at the edge.
- Coalesce condition (co), all must hold:
  - st_valid is high.
  - count ≥ 1.
  - st_addr[31:2] equals the waddr of the youngest entry (tail-1).
  - Not (count == 1 && dm_wr), meaning the youngest entry is not leaving this cycle.
- On co, the youngest entry merges the new store: bytes with st_be[i]=1 are overwritten, be |= st_be. Tail and count are unchanged.
- Push: st_valid && st_ready && !co. The entry is written at tail, and tail increments.
- st_ready = !full || co. A full buffer does not accept a non-coalescing store even if it is draining in the same cycle.
- count_next = count + push − dm_wr.
- st_be == 0 with st_valid: the store is accepted and consumes an entry (or merges as a no-op). DM then sees dm_wr with dm_be = 0.
- Forwarding, per byte i:
  - Byte i comes from the youngest entry with waddr == ld_addr[31:2] and be[i] = 1. Priority is from tail-1 back to head, over valid entries only.
  - If no entry matches, byte i comes from dm_rdata.
  - ld_hit[i] = 1 when byte i is forwarded.
  - An entry draining this cycle still forwards.
  - A store presented in the same cycle is not forwarded; the pipeline orders it.
- Forwarding is purely combinational from state, ld_addr and dm_rdata.

## Timing
- Reset (async assert): count = 0, head = tail = 0, empty = 1, dm_wr = 0, st_ready = 1, ld_hit = 0. All entry be fields are cleared.
- Reset mid-operation: all pending stores are discarded. DM is not written in the cycle after deassertion.
- Latency:
  - A store accepted at edge E0 appears at head no earlier than the cycle after E0.
  - With drain_en held high and an empty buffer, DM is written at edge E1 (one cycle).
  - There is no same-cycle bypass from st_* to dm_*.
- Throughput: one push and one drain per cycle sustained. Count holds steady at any level in 1..DEPTH−1.
- Full (count == DEPTH) with drain: st_ready = 0 for non-coalescing stores. Count drops to DEPTH−1 at the edge.
- Empty with drain_en: dm_wr = 0, no pointer change.
- A forwarded value becomes visible the cycle after the store is accepted. Forwarding persists until the entry drains; after the drain edge, dm_rdata supplies the byte.

## Test plan
- Reset, then st 0x100 be=1111 data=0xDEADBEEF with drain_en=1. Require dm_wr=1, dm_addr=0x100, dm_din=0xDEADBEEF in the next cycle; count 1→0.
- drain_en=0; sb 0x204 data=0x11111111 be=0001, then next cycle sb 0x206 data=0x22222222 be=0100. Require count=1 and entry be=0101. A load at 0x204 with dm_rdata=0xAAAAAAAA gives ld_rdata=0xAA22AA11 and ld_hit=0101.
- drain_en=0; push 4 distinct words. Require st_ready=0 for a 5th distinct word and count=4. st_ready=1 for a store to the 4th word's address (coalesce). Asserting drain_en drains entries in order, 4 cycles.
- Stores A, B, A (A = 0x300, be=1111, data 1 then 3). Require 3 entries, with the load at A forwarding 3 (youngest wins).
- count=1 draining this cycle while a same-word store arrives. Require no merge: push to a new entry, count stays 1, dm_din shows the old data.
- Assert rst with 3 entries pending. Require empty=1, dm_wr=0, ld_hit=0 immediately, and no DM writes after release.
